// File: rtl/bias_rail_sequencer.sv
// Break-before-make bias-rail sequencer: walks rail switch selects between table-defined modes.
// Define BIAS_SEQ_PGOOD_EN to compile in power-good supervision and the latched FAULT state.
module bias_rail_sequencer #(
    parameter int                           N_RAILS       = 3,
    parameter int                           N_MODES       = 4,
    parameter logic [N_MODES*N_RAILS-1:0]   MODE_TABLE    = 12'hCC8,
    parameter int                           BREAK_CYCLES  = 100,
    parameter int                           SETTLE_CYCLES = 1000,
    parameter int                           MODE_W        = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [MODE_W-1:0]  req_mode,
    output logic               req_ready,
    output logic [N_RAILS-1:0] rail_sel,
    output logic [MODE_W-1:0]  cur_mode,
    output logic               busy,
    output logic               mode_valid,
    output logic               done,
    output logic               req_err,
    input  logic [N_RAILS-1:0] rail_pgood,
    output logic               fault,
    input  logic               fault_clr
);

    localparam int CNT_MAX = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAKE  = 3'd2,
        READY = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [N_RAILS-1:0] rail_n;
    logic [MODE_W-1:0]  cur_n, tgt_mode, tgt_n;
    logic               done_n, err_n;
    logic               accept, req_bad;
    logic [N_RAILS-1:0] req_rails, tgt_rails;
    logic               ready_trip, make_trip, clr;

    function automatic logic [N_RAILS-1:0] mode_rails(input logic [MODE_W-1:0] m);
        mode_rails = '0;
        for (int i = 0; i < N_MODES; i++)
            if (m == MODE_W'(i))
                mode_rails = MODE_TABLE[i*N_RAILS +: N_RAILS];
    endfunction

    assign req_rails  = mode_rails(req_mode);
    assign tgt_rails  = mode_rails(tgt_mode);
    assign req_ready  = (state == IDLE) || (state == READY);
    assign busy       = (state == BREAK) || (state == MAKE);
    assign mode_valid = (state == READY);
    assign accept     = req_valid && req_ready;
    // Extra bit so the range check still works when N_MODES is a power of two filling MODE_W.
    assign req_bad    = {1'b0, req_mode} >= (MODE_W+1)'(N_MODES);

`ifdef BIAS_SEQ_PGOOD_EN
    assign ready_trip = (state == READY) && (rail_pgood != rail_sel);
    assign make_trip  = (rail_pgood != tgt_rails);
    assign clr        = fault_clr;
    assign fault      = (state == FAULT);
`else
    logic unused_pgood;
    assign unused_pgood = ^{rail_pgood, fault_clr};
    assign ready_trip   = 1'b0;
    assign make_trip    = 1'b0;
    assign clr          = 1'b0;
    assign fault        = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rail_n  = rail_sel;
        cur_n   = cur_mode;
        tgt_n   = tgt_mode;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE, READY: begin
                if (ready_trip) begin
                    state_n = FAULT;
                    rail_n  = '0;
                end else if (accept) begin
                    if (req_bad) begin
                        err_n = 1'b1;
                    end else if (state == READY && req_mode == cur_mode) begin
                        done_n = 1'b1;
                    end else begin
                        // Break phase only opens switches: keep rails shared with the target.
                        state_n = BREAK;
                        tgt_n   = req_mode;
                        cnt_n   = CNT_W'(BREAK_CYCLES - 1);
                        rail_n  = rail_sel & req_rails;
                    end
                end
            end
            BREAK: begin
                if (cnt == '0) begin
                    state_n = MAKE;
                    cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
                    rail_n  = tgt_rails;
                    cur_n   = tgt_mode;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            MAKE: begin
                if (cnt == '0) begin
                    if (make_trip) begin
                        state_n = FAULT;
                        rail_n  = '0;
                    end else begin
                        state_n = READY;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            FAULT: begin
                rail_n = '0;
                if (clr)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                rail_n  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rail_sel <= '0;
            cur_mode <= '0;
            tgt_mode <= '0;
            done     <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rail_sel <= rail_n;
            cur_mode <= cur_n;
            tgt_mode <= tgt_n;
            done     <= done_n;
            req_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_bias_rail_sequencer.sv
// Directed bench for bias_rail_sequencer with BREAK=4, SETTLE=10, default table, MODE_W widened to 3.
// Power-good expectations follow BIAS_SEQ_PGOOD_EN as seen by this file.
module tb_bias_rail_sequencer;

    localparam int B = 4;
    localparam int S = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic [2:0] rail_sel;
    logic [2:0] cur_mode;
    logic       busy, mode_valid, done, req_err, fault, fault_clr;
    logic [2:0] rail_pgood;

    int errors = 0;
    int checks = 0;

    bias_rail_sequencer #(
        .N_RAILS(3), .N_MODES(4), .MODE_TABLE(12'hCC8),
        .BREAK_CYCLES(B), .SETTLE_CYCLES(S), .MODE_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .rail_sel(rail_sel), .cur_mode(cur_mode), .busy(busy),
        .mode_valid(mode_valid), .done(done), .req_err(req_err),
        .rail_pgood(rail_pgood), .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a mode request and follow it to its end cycle (done or fault); leaves bench there.
    task automatic run_seq(input logic [2:0] m, input logic [2:0] brk, input logic [2:0] mk,
                           input logic [2:0] pg, input bit exp_fault, input string tag);
        logic [2:0] prev;
        int bad_rail, bad_ctl, overlap;
        bad_rail = 0; bad_ctl = 0; overlap = 0;
        prev = rail_sel;
        req_valid = 1'b1;
        req_mode  = m;
        step();
        req_valid  = 1'b0;
        rail_pgood = pg;
        for (int i = 0; i < B + S; i++) begin
            if (rail_sel !== ((i < B) ? brk : mk)) bad_rail++;
            if (busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0 || mode_valid !== 1'b0) bad_ctl++;
            if (|(rail_sel & ~prev) && |(prev & ~rail_sel)) overlap++;
            prev = rail_sel;
            step();
        end
        if (|(rail_sel & ~prev) && |(prev & ~rail_sel)) overlap++;
        check({tag, "_rails"}, bad_rail, 0);
        check({tag, "_busy"}, bad_ctl, 0);
        check({tag, "_bbm"}, overlap, 0);
        check({tag, "_cur"}, cur_mode, m);
        check({tag, "_nbusy"}, busy, 1'b0);
        if (exp_fault) begin
            check({tag, "_fault"}, fault, 1'b1);
            check({tag, "_frail"}, rail_sel, 3'b000);
            check({tag, "_fdone"}, done, 1'b0);
            check({tag, "_fvalid"}, mode_valid, 1'b0);
            check({tag, "_fready"}, req_ready, 1'b0);
        end else begin
            check({tag, "_done"}, done, 1'b1);
            check({tag, "_valid"}, mode_valid, 1'b1);
            check({tag, "_final"}, rail_sel, mk);
            check({tag, "_nofault"}, fault, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; fault_clr = 1'b0; rail_pgood = '0;
        step();
        step();
        check("rst_rail", rail_sel, 3'b000);
        check("rst_cur", cur_mode, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", mode_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", req_err, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        step();

        run_seq(3'd0, 3'b000, 3'b000, 3'b000, 1'b0, "m0");
        step();
        check("m0_pulse", done, 1'b0);

        run_seq(3'd2, 3'b000, 3'b011, 3'b011, 1'b0, "m2");
        // Accepted in the same cycle done is high.
        run_seq(3'd3, 3'b010, 3'b110, 3'b110, 1'b0, "m3");
        step();
        run_seq(3'd1, 3'b000, 3'b001, 3'b001, 1'b0, "m1");
        step();

        req_valid = 1'b1; req_mode = 3'd1;
        step();
        req_valid = 1'b0;
        check("same_done", done, 1'b1);
        check("same_busy", busy, 1'b0);
        check("same_rail", rail_sel, 3'b001);
        step();
        check("same_pulse", done, 1'b0);
        check("same_valid", mode_valid, 1'b1);

        req_valid = 1'b1; req_mode = 3'd5;
        step();
        req_valid = 1'b0;
        check("err_pulse", req_err, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_rail", rail_sel, 3'b001);
        check("err_cur", cur_mode, 3'd1);
        check("err_valid", mode_valid, 1'b1);
        step();
        check("err_clear", req_err, 1'b0);

`ifdef BIAS_SEQ_PGOOD_EN
        run_seq(3'd2, 3'b001, 3'b011, 3'b001, 1'b1, "pg");
        step();
        check("pg_hold", fault, 1'b1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clr_fault", fault, 1'b0);
        check("clr_ready", req_ready, 1'b1);
        check("clr_rail", rail_sel, 3'b000);
        check("clr_cur", cur_mode, 3'd2);
        check("clr_valid", mode_valid, 1'b0);
        run_seq(3'd2, 3'b000, 3'b011, 3'b011, 1'b0, "pg_rec");
        step();
        rail_pgood = 3'b010;
        step();
        check("rdy_trip", fault, 1'b1);
        check("rdy_trip_rail", rail_sel, 3'b000);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        run_seq(3'd2, 3'b000, 3'b011, 3'b011, 1'b0, "pg_rec2");
`else
        run_seq(3'd2, 3'b001, 3'b011, 3'b001, 1'b0, "pg_off");
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clr_ignored", mode_valid, 1'b1);
        check("clr_rail", rail_sel, 3'b011);
`endif
        step();

        req_valid = 1'b1; req_mode = 3'd3;
        step();
        req_valid  = 1'b0;
        rail_pgood = 3'b110;
        repeat (B + 2) step();
        check("mid_make_rail", rail_sel, 3'b110);
        rst_n = 1'b0;
        #1;
        check("arst_rail", rail_sel, 3'b000);
        check("arst_busy", busy, 1'b0);
        check("arst_cur", cur_mode, 3'd0);
        check("arst_done", done, 1'b0);
        check("arst_valid", mode_valid, 1'b0);
        check("arst_fault", fault, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("post_ready", req_ready, 1'b1);
        check("post_done", done, 1'b0);
        check("post_rail", rail_sel, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
